// File: rtl/slc3_io_bridge_pkg.sv
// Shared types and defaults for the SLC-3 I/O bridge.
//   pause_state_t   : pause/continue handshake FSM encoding
//   IO_BASE_DEFAULT : top address of the memory-mapped I/O window
package slc3_io_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_DONE   = 2'd2,
        ST_DROP   = 2'd3
    } pause_state_t;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slc3_io_bridge_if.sv
// CPU-side memory port and pause handshake of the SLC-3 I/O bridge.
//   master : CPU side (drives address/data/strobes and pause request)
//   slave  : bridge side (returns io_sel, read data/valid and pause_done)
interface slc3_io_bridge_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LED_W  = 10
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic              io_sel;
    logic [DATA_W-1:0] io_rdata;
    logic              io_rvalid;
    logic              pause_req;
    logic [LED_W-1:0]  pause_led;
    logic              pause_done;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re, pause_req, pause_led,
        input  io_sel, io_rdata, io_rvalid, pause_done
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re, pause_req, pause_led,
        output io_sel, io_rdata, io_rvalid, pause_done
    );

endinterface

// File: rtl/slc3_io_bridge_key_debouncer.sv
// Synchronises and debounces an active-low push key.
//   clk_i, rst_i : clock, synchronous active-high reset
//   raw_i        : raw active-low key, asynchronous to clk_i
//   level_o      : debounced level, 1 = pressed
//   press_o      : one-cycle pulse on the released->pressed transition
module key_debouncer #(
    parameter int CYC = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;

    logic          meta_q, sync_q;
    logic          level_q, press_q;
    logic [CW-1:0] cnt_q;
    logic          pressed_raw;

    assign pressed_raw = ~sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= CW'(CYC - 1);
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            press_q <= 1'b0;
            // Any return to the accepted level reloads the timer, so only an
            // unbroken run of CYC differing samples flips the level.
            if (pressed_raw == level_q) begin
                cnt_q <= CW'(CYC - 1);
            end else if (cnt_q == '0) begin
                level_q <= pressed_raw;
                press_q <= pressed_raw;
                cnt_q   <= CW'(CYC - 1);
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/slc3_io_bridge.sv
// Memory-mapped I/O bridge between the SLC-3 CPU port and DE10-Lite board I/O.
//   Clk, Reset  : clock, synchronous active-high reset
//   Continue_n  : raw active-low Continue key
//   SW          : raw switches, read back at IO_BASE (zero-extended)
//   LED         : LED drive, latched from pause_led on pause entry
//   hex_nib     : NUM_CH hex words, channel k at IO_BASE-k, bits [16k+15:16k]
//   bus         : CPU memory port and pause handshake (slave side)
// State table for the pause FSM:
//   RUN    | normal execution, LED holds; pause_req latches pause_led
//   PAUSED | waiting for a Continue press
//   DONE   | pause_done high for one cycle
//   DROP   | waiting for the CPU to drop pause_req
module slc3_io_bridge
    import slc3_io_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 16,
    parameter int                SW_W         = 10,
    parameter int                LED_W        = 10,
    parameter int                NUM_CH       = 2,
    parameter logic [ADDR_W-1:0] IO_BASE      = ADDR_W'(IO_BASE_DEFAULT),
    parameter int                DEBOUNCE_CYC = 50000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Continue_n,
    input  logic [SW_W-1:0]       SW,
    output logic [LED_W-1:0]      LED,
    output logic [NUM_CH*16-1:0]  hex_nib,
    slc3_io_bridge_if.slave       bus
);

    logic [ADDR_W-1:0]    ch;
    logic                 hit;
    logic [SW_W-1:0]      sw_meta_q, sw_sync_q;
    logic [NUM_CH*16-1:0] hex_q;
    logic [DATA_W-1:0]    rd_word;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rvalid_q;
    logic                 key_level, key_press;
    pause_state_t         state_q;
    logic [LED_W-1:0]     led_q;
    logic                 done_q;

    // Addresses above IO_BASE would wrap the subtraction into a small channel
    // number, so they are excluded explicitly.
    assign ch  = IO_BASE - bus.mem_addr;
    assign hit = (bus.mem_addr <= IO_BASE) && (ch < ADDR_W'(NUM_CH));
    assign bus.io_sel = hit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Channel 0 is write-only towards the display; reading it returns the switches.
    always_comb begin
        rd_word = DATA_W'(sw_sync_q);
        for (int k = 1; k < NUM_CH; k++) begin
            if (ch == ADDR_W'(k)) rd_word = DATA_W'(hex_q[16*k +: 16]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus.mem_re && hit;
            if (bus.mem_re && hit) rdata_q <= rd_word;
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.mem_we && hit && (ch == ADDR_W'(k))) begin
                    hex_q[16*k +: 16] <= bus.mem_wdata[15:0];
                end
            end
        end
    end

    key_debouncer #(.CYC(DEBOUNCE_CYC)) u_key (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .raw_i   (Continue_n),
        .level_o (key_level),
        .press_o (key_press)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_RUN;
            led_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    if (bus.pause_req) begin
                        led_q   <= bus.pause_led;
                        state_q <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    // A withdrawn request wins over a simultaneous press.
                    if (!bus.pause_req) begin
                        state_q <= ST_RUN;
                    end else if (key_press && key_level) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DROP;
                end
                ST_DROP: begin
                    if (!bus.pause_req) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign LED            = led_q;
    assign hex_nib        = hex_q;
    assign bus.io_rdata   = rdata_q;
    assign bus.io_rvalid  = rvalid_q;
    assign bus.pause_done = done_q;

endmodule
